// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a multiplexed, active-low 7-segment bus
// (cathodes seg_in[6:0] = g..a, anodes an_in[3:0], bit3 = leftmost digit).
// It rebuilds the four displayed hex digits and flags undecodable patterns
// and stopped scanning. It pulses frame_valid once per completed scan frame.
//
// Strobe semantics: frame_valid is a single-cycle pulse with no back-pressure.
// digits/digit_valid/blank change only in the cycle frame_valid is high and
// then hold until the next frame. frame_err is only ever high together with
// frame_valid.
module seg_scan_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stale
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  // Returns {blank, valid, nibble} for one cathode pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] r;
    r = 6'b00_0000;
    case (s)
      7'h40: r = {2'b01, 4'h0};
      7'h79: r = {2'b01, 4'h1};
      7'h24: r = {2'b01, 4'h2};
      7'h30: r = {2'b01, 4'h3};
      7'h19: r = {2'b01, 4'h4};
      7'h12: r = {2'b01, 4'h5};
      7'h02: r = {2'b01, 4'h6};
      7'h78: r = {2'b01, 4'h7};
      7'h00: r = {2'b01, 4'h8};
      7'h10: r = {2'b01, 4'h9};
      7'h08: r = {2'b01, 4'hA};
      7'h03: r = {2'b01, 4'hB};
      7'h46: r = {2'b01, 4'hC};
      7'h21: r = {2'b01, 4'hD};
      7'h06: r = {2'b01, 4'hE};
      7'h0E: r = {2'b01, 4'hF};
      7'h7F: r = {2'b10, 4'h0};
      default: r = 6'b00_0000;
    endcase
    return r;
  endfunction

  logic [6:0] seg_sync_q [SYNC_STAGES];
  logic [3:0] an_sync_q  [SYNC_STAGES];
  logic [6:0] seg_s, seg_prev_q;
  logic [3:0] an_s, an_prev_q, an_low;
  logic       legal, same, capture;
  logic [1:0] idx;
  logic [5:0] dec;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic [3:0][3:0] shadow_nib_q, shadow_nib_d;
  logic [3:0]      shadow_val_q, shadow_val_d;
  logic [3:0]      shadow_blk_q, shadow_blk_d;
  logic [3:0]      mask_q, mask_d, mask_base;
  logic            frame_done_q, frame_done_d;

  // Synchronise the asynchronous display bus before it touches any logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        seg_sync_q[i] <= '0;
        an_sync_q[i]  <= '0;
      end
    end else begin
      seg_sync_q[0] <= seg_in;
      an_sync_q[0]  <= an_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        seg_sync_q[i] <= seg_sync_q[i-1];
        an_sync_q[i]  <= an_sync_q[i-1];
      end
    end
  end

  assign seg_s  = seg_sync_q[SYNC_STAGES-1];
  assign an_s   = an_sync_q[SYNC_STAGES-1];
  assign an_low = ~an_s;
  assign legal  = (an_low != 4'h0) && ((an_low & (an_low - 4'h1)) == 4'h0);
  assign same   = (seg_s == seg_prev_q) && (an_s == an_prev_q);
  // The counter reads STABLE_CYCLES-2 on the (STABLE_CYCLES-1)-th identical
  // sample, so this fires on the STABLE_CYCLES-th one, once per dwell.
  assign capture = legal && same && (cnt_q == CNT_CAP);
  assign dec     = decode_seg(seg_s);

  // Digit index from the single active anode.
  always_comb begin
    idx = 2'd0;
    case (an_low)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Dwell counter and stale timeout next-state.
  always_comb begin
    cnt_d = cnt_q;
    if (!legal || !same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    to_d = to_q;
    if (capture) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + TO_W'(1);
    end
  end

  // Shadow capture and frame-completion detection. The mask clears in the
  // cycle the completed frame is published.
  always_comb begin
    shadow_nib_d = shadow_nib_q;
    shadow_val_d = shadow_val_q;
    shadow_blk_d = shadow_blk_q;
    mask_base    = frame_done_q ? 4'h0 : mask_q;
    mask_d       = mask_base;
    frame_done_d = 1'b0;
    if (capture) begin
      shadow_nib_d[idx] = dec[3:0];
      shadow_val_d[idx] = dec[4];
      shadow_blk_d[idx] = dec[5];
      mask_d            = mask_base | an_low;
      frame_done_d      = ((mask_base | an_low) == 4'hF);
    end
  end

  // Sample history, counters and shadow state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_prev_q   <= '0;
      an_prev_q    <= '0;
      cnt_q        <= '0;
      to_q         <= '0;
      shadow_nib_q <= '0;
      shadow_val_q <= '0;
      shadow_blk_q <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seg_prev_q   <= seg_s;
      an_prev_q    <= an_s;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      shadow_nib_q <= shadow_nib_d;
      shadow_val_q <= shadow_val_d;
      shadow_blk_q <= shadow_blk_d;
      mask_q       <= mask_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Publish a completed frame one cycle after its final capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits      <= '0;
      digit_valid <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= frame_done_q;
      frame_err   <= 1'b0;
      if (frame_done_q) begin
        digits      <= shadow_nib_q;
        digit_valid <= shadow_val_q;
        blank       <= shadow_blk_q;
        frame_err   <= |(~shadow_val_q & ~shadow_blk_q);
      end
    end
  end

  assign stale = (to_q == TO_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus randomized scans, checked
// against a dwell-based reference model and an expected-frame queue.
module tb_seg_scan_decoder;

  localparam int S  = 16;
  localparam int TO = 1000;
  localparam int W  = 25;   // {frame_err, blank[3:0], valid[3:0], digits[15:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits;
  logic [3:0]  digit_valid, blank;
  logic        frame_valid, frame_err, stale;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  int frame_cnt = 0;
  int fv_cyc = 0;
  int stale_rise_cyc = -1;
  int stale_fall_cyc = -1;
  int drv_start = 0;
  logic [15:0] last_digits;
  logic [3:0]  last_valid, last_blank;
  logic        last_err;

  // Reference model state: current run of identical input samples.
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  int          m_run;
  logic [15:0] m_dig;
  logic [3:0]  m_val, m_blk, m_mask;

  logic [6:0] hex_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_decoder #(
    .SYNC_STAGES(2),
    .STABLE_CYCLES(S),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .an_in(an_in),
    .digits(digits),
    .digit_valid(digit_valid),
    .blank(blank),
    .frame_valid(frame_valid),
    .frame_err(frame_err),
    .stale(stale)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    if (s == 7'h7F) return 6'b10_0000;
    for (int i = 0; i < 16; i++)
      if (hex_pat[i] == s) return {2'b01, 4'(i)};
    return 6'b00_0000;
  endfunction

  function automatic void model_reset();
    m_seg = 7'h7F; m_an = 4'hF; m_run = 0;
    m_dig = '0; m_val = '0; m_blk = '0; m_mask = '0;
  endfunction

  // A legal sample held for S consecutive cycles is captured once.
  function automatic void model_step(input logic [6:0] s, input logic [3:0] a, input int n);
    int prior;
    int idx;
    logic [5:0] d;
    prior = (s == m_seg && a == m_an) ? m_run : 0;
    m_seg = s; m_an = a; m_run = prior + n;
    if ($countones(~a) == 1 && prior < S && m_run >= S) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
      d = ref_decode(s);
      m_dig[idx*4 +: 4] = d[3:0];
      m_val[idx] = d[4];
      m_blk[idx] = d[5];
      m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) begin
        exp_q.push_back({|(~m_val & ~m_blk), m_blk, m_val, m_dig});
        m_mask = 4'h0;
      end
    end
  endfunction

  // Driver: called at a negedge; holds the pattern for n clock edges.
  task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n);
    seg_in = s;
    an_in = a;
    drv_start = cyc;
    model_step(s, a, n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    seg_in = 7'h7F;
    an_in = 4'hF;
    reset = 1'b0;
    model_reset();
    repeat (n) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_blank", 32'(blank), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    reset = 1'b1;
  endtask

  task automatic scan_0064(input int n);
    drive(7'h40, 4'b0111, n);
    drive(7'h40, 4'b1011, n);
    drive(7'h02, 4'b1101, n);
    drive(7'h19, 4'b1110, n);
  endtask

  // Scoreboard monitor: samples 1 time unit after each rising edge.
  initial begin
    logic prev_stale;
    logic [W-1:0] e;
    prev_stale = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (stale && !prev_stale) stale_rise_cyc = cyc;
      if (!stale && prev_stale) stale_fall_cyc = cyc;
      prev_stale = stale;
      if (frame_err) chk("err_needs_fv", 32'(frame_valid), 32'h1);
      if (frame_valid) begin
        frame_cnt++;
        fv_cyc = cyc;
        last_digits = digits; last_valid = digit_valid;
        last_blank = blank; last_err = frame_err;
        chk("stale_at_frame", 32'(stale), 32'h0);
        chk("frame_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_digits", 32'(digits), 32'(e[15:0]));
          chk("frame_valid_bits", 32'(digit_valid), 32'(e[19:16]));
          chk("frame_blank", 32'(blank), 32'(e[23:20]));
          chk("frame_err", 32'(frame_err), 32'(e[24]));
        end
      end
    end
  end

  // Stimulus
  initial begin
    int order [4];
    int j, tmp, r, n;
    logic [6:0] s;
    logic [3:0] a;

    do_reset(4);

    // Forward scan 0,0,6,4 with 18-cycle publish latency.
    scan_0064(100);
    chk("t1_latency", fv_cyc - drv_start - 1, 18);
    chk("t1_frames", frame_cnt, 1);
    chk("t1_digits", 32'(last_digits), 32'h0064);
    chk("t1_valid", 32'(last_valid), 32'hF);
    chk("t1_blank", 32'(last_blank), 32'h0);
    chk("t1_err", 32'(last_err), 32'h0);

    // 10-cycle glitch inside digit 2 is never captured.
    drive(7'h40, 4'b0111, 100);
    drive(7'h40, 4'b1011, 40);
    drive(7'h79, 4'b1011, 10);
    drive(7'h40, 4'b1011, 50);
    drive(7'h02, 4'b1101, 100);
    drive(7'h19, 4'b1110, 100);
    chk("t2_frames", frame_cnt, 2);
    chk("t2_digits", 32'(last_digits), 32'h0064);

    // Blank digit 0, undefined digit 1.
    drive(7'h40, 4'b0111, 60);
    drive(7'h40, 4'b1011, 60);
    drive(7'h7E, 4'b1101, 60);
    drive(7'h7F, 4'b1110, 60);
    chk("t3_frames", frame_cnt, 3);
    chk("t3_blank", 32'(last_blank), 32'h1);
    chk("t3_valid", 32'(last_valid), 32'hC);
    chk("t3_err", 32'(last_err), 32'h1);
    chk("t3_digits", 32'(last_digits), 32'h0);

    // Illegal anodes between half frames: no capture, mask retained.
    drive(7'h79, 4'b0111, 50);
    drive(7'h24, 4'b1011, 50);
    drive(7'h30, 4'b1100, 200);
    drive(7'h30, 4'b1111, 200);
    chk("t4_no_strobe", frame_cnt, 3);
    drive(7'h30, 4'b1101, 50);
    drive(7'h12, 4'b1110, 50);
    chk("t4_frames", frame_cnt, 4);
    chk("t4_digits", 32'(last_digits), 32'h1235);

    // Dwell boundary: 15 samples never capture, 16 do.
    drive(7'h30, 4'b0111, 16);
    drive(7'h79, 4'b1011, 16);
    drive(7'h24, 4'b1101, 16);
    drive(7'h12, 4'b1110, 15);
    drive(7'h7F, 4'b1111, 20);
    chk("b_no_frame_15", frame_cnt, 4);
    drive(7'h19, 4'b1110, 16);
    drive(7'h7F, 4'b1111, 20);
    chk("b_frames", frame_cnt, 5);
    chk("b_digits", 32'(last_digits), 32'h3124);

    // Stale detection and recovery.
    chk("t5_stale_idle", 32'(stale), 32'h0);
    scan_0064(100);
    drive(7'h7F, 4'b1111, 1100);
    chk("t5_stale_rise", stale_rise_cyc - fv_cyc, TO - 1);
    chk("t5_stale_high", 32'(stale), 32'h1);
    drive(7'h40, 4'b0111, 100);
    chk("t5_stale_fall", stale_fall_cyc - drv_start - 1, S + 1);
    chk("t5_stale_low", 32'(stale), 32'h0);
    drive(7'h40, 4'b1011, 100);
    drive(7'h02, 4'b1101, 100);
    drive(7'h19, 4'b1110, 100);
    chk("t5_frames", frame_cnt, 7);

    // Reset after three captures discards the partial frame.
    drive(7'h40, 4'b0111, 30);
    drive(7'h79, 4'b1011, 30);
    drive(7'h24, 4'b1101, 30);
    drive(7'h7F, 4'b1111, 10);
    chk("t6_pending", exp_q.size(), 0);
    do_reset(3);
    drive(7'h7F, 4'b1111, 10);
    drive(7'h30, 4'b1110, 30);
    drive(7'h7F, 4'b1111, 40);
    chk("t6_no_frame", frame_cnt, 7);
    drive(7'h40, 4'b0111, 30);
    drive(7'h79, 4'b1011, 30);
    drive(7'h24, 4'b1101, 30);
    drive(7'h7F, 4'b1111, 30);
    chk("t6_frames", frame_cnt, 8);
    chk("t6_digits", 32'(last_digits), 32'h0123);

    // Randomized scans in random order with short dwells and illegal gaps.
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 4; k++) order[k] = k;
      for (int k = 3; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = order[k]; order[k] = order[j]; order[j] = tmp;
      end
      for (int k = 0; k < 4; k++) begin
        r = $urandom_range(0, 9);
        if (r < 7) s = hex_pat[$urandom_range(0, 15)];
        else if (r == 7) s = 7'h7F;
        else s = 7'($urandom_range(0, 127));
        n = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 15) : $urandom_range(16, 60);
        a = ~(4'b0001 << order[k]);
        drive(s, a, n);
        if ($urandom_range(0, 5) == 0) begin
          do a = 4'($urandom_range(0, 15)); while ($countones(~a) == 1);
          drive(7'($urandom_range(0, 127)), a, $urandom_range(1, 30));
        end
      end
    end
    drive(7'h7F, 4'b1111, 40);
    chk("pending_at_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Listens to the multiplexed 7-segment bus that the game top level drives: active-low cathodes `seg` and active-low anodes `an` on the Nexys A7 at 100 MHz.
- Reconstructs the four displayed hex digits, flags unrecognised patterns and stale scanning, and emits one strobe per complete scan frame.
- Used as a synthesizable display monitor in self-checking benches and for on-board readback of the displayed value.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on `seg_in` and `an_in` before any logic (minimum 1).
- STABLE_CYCLES, 16, consecutive identical synchronised samples required before a digit is accepted (minimum 2).
- TIMEOUT_CYCLES, 2000000, cycles without any accepted digit before `stale` asserts (20 ms).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- seg_in  in  7  cathodes, active-low; bit0=a through bit6=g.
- an_in  in  4  anodes, active-low; bit3 = leftmost digit.
- digits  out  16  last complete frame; nibble i is digit i.
- digit_valid  out  4  bit i set when digit i's pattern was recognised in the last frame.
- blank  out  4  bit i set when digit i was all-off (7'h7F) in the last frame.
- frame_valid  out  1  one-cycle strobe; outputs above updated this cycle.
- frame_err  out  1  one-cycle strobe with `frame_valid` when any `digit_valid` bit is 0 and the matching `blank` bit is also 0.
- stale  out  1  level: scanning has stopped.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, sync chains 0.
  - Stability counter 0, captured-mask 0, timeout counter 0, shadow registers 0.
- Decode (seg active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E, blank=7F.
  - Any other pattern: nibble 0, valid 0, blank 0.
- Sample legality: the synchronised `an` has exactly one bit low. Samples with all bits high or with 2+ bits low are illegal.
- Stability:
  - Counter increments while the sample equals the previous sample and is legal.
  - Counter clears to 0 on any change or any illegal sample.
  - Saturates at STABLE_CYCLES.
- Capture:
  - Occurs in the cycle the counter reaches STABLE_CYCLES-1, i.e. on the STABLE_CYCLES-th identical sample. Once per dwell; no re-capture until the sample changes.
  - Writes the shadow nibble, valid and blank bits for index i, and sets captured-mask bit i.
  - Re-capturing the same index before the frame completes overwrites its shadow entry.
- Frame completion:
  - Happens on the capture cycle that makes captured-mask = 4'b1111.
  - Registered one cycle later: `digits`, `digit_valid`, `blank` load from shadow; `frame_valid` pulses; `frame_err` is computed from the loaded values.
  - Mask clears in the same cycle as the load. The next capture in that cycle sets only its own bit.
- Latency: from the first `seg`/`an` edge of the final digit to `frame_valid` = SYNC_STAGES + STABLE_CYCLES cycles (18 at defaults).
- Stale detection:
  - Timeout counter clears on every capture and otherwise increments, saturating.
  - `stale` = 1 once the counter reaches TIMEOUT_CYCLES; clears on the next capture.
  - `stale` does not clear the mask or outputs.
- Scan order is irrelevant; forward, reverse or random order all complete frames.
- Reset mid-frame discards partial shadow and mask; no `frame_valid` is produced for the interrupted frame.

Test Plan:
- Scan order an=0111/1011/1101/1110 with seg=40/40/02/19, dwell 100 cycles each:
  - `frame_valid` pulses exactly 18 cycles after the final digit's edge.
  - `digits`=16'h0064, `digit_valid`=4'hF, `blank`=0, `frame_err`=0.
- Same scan, but digit 2 carries a 10-cycle glitch to seg=79 within its dwell:
  - Glitch is never captured; `digits` remain 16'h0064.
- Digit 0 driven seg=7F (blank) and digit 1 driven seg=7E (undefined):
  - `blank`=4'b0001, `digit_valid`=4'b1100, `frame_err` pulses with `frame_valid`.
- an=1100 or an=1111 held for 200 cycles:
  - No capture, mask unchanged, no strobe.
- Scanning stopped after one frame, TIMEOUT_CYCLES overridden to 1000:
  - `stale` rises on cycle 1000 after the last capture.
  - `stale` falls on the first capture after scanning resumes.
- `reset` pulled low after 3 digits captured, then released:
  - Outputs read 0.
  - The next `frame_valid` occurs only after all 4 digits are re-captured.
